tilelink_ul_mem_slave: RTL and testbench
========================================

Name: tilelink_ul_mem_slave

Overview:
- Synthesizable TileLink-UL memory slave with 32-bit data. It sits directly downstream of the Rocket tile master port (io_master_0_a_* / io_master_0_d_*).
- Holds real, word-addressed storage, so fetched instructions and loads return previously written data.
- Accepts Get, PutFullData and PutPartialData with multi-beat bursts.
- Answers unsupported opcodes with error responses, so the core's D-channel handling can be exercised against real memory contents.

Parameters:
- BASE_ADDR, 32'h0001_0000: first byte address served; matches the core reset vector.
- MEM_WORDS, 256: depth in 32-bit words; power of two.
- MAX_SIZE, 6: largest legal lg2 transfer size (64 B = 16 beats).

Ports:
- clock  in  1  single clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- a_ready  out  1  A-channel ready.
- a_valid  in  1  A-channel valid.
- a_opcode  in  3  A opcode.
- a_param  in  3  A param; ignored.
- a_size  in  4  lg2 bytes.
- a_source  in  1  requester id.
- a_address  in  32  byte address.
- a_mask  in  4  byte lanes.
- a_data  in  32  put data.
- d_ready  in  1  D-channel ready.
- d_valid  out  1  D-channel valid.
- d_opcode  out  3  D opcode.
- d_param  out  2  always 0.
- d_size  out  4  echoed size.
- d_source  out  1  echoed source.
- d_sink  out  1  always 0.
- d_addr_lo  out  2  op_address[1:0].
- d_data  out  32  read data; 0 on error.
- d_error  out  1  error flag.
- stall_a  in  1  forces a_ready low; bench backpressure.
- stall_d  in  1  forces d_valid low; bench backpressure.
- proto_err  out  1  sticky flag; set on an illegal request.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; a_ready=0, d_valid=0, proto_err=0.
  - All memory words cleared to 0.
  - An in-flight operation is dropped with no response.
  - a_ready=0 while reset_n=0.
- Beat count: beats = (a_size<=2) ? 1 : 1<<(a_size-2). A 4-bit beat counter wraps only on the final beat.
- Error condition, latched at the first A beat as op_err:
  - address outside [BASE_ADDR, BASE_ADDR+4*MEM_WORDS); or
  - address not aligned to 1<<size; or
  - size>MAX_SIZE.
  - size>MAX_SIZE also sets proto_err, and the request is treated as 1 beat.
- Word index = (op_address - BASE_ADDR)>>2 + beat, truncated to log2(MEM_WORDS) bits.
- FSM states: IDLE, PUT_COLLECT, GET_RESP, PUT_ACK.
  - a_ready = (IDLE or PUT_COLLECT) && !stall_a.
  - d_valid = (GET_RESP or PUT_ACK) && !stall_d.
  - No A accept in the same cycle as a D beat, so at most one outstanding op.
- IDLE, A fire:
  - Latch opcode, size, source, address, op_err; beat counter = 0.
  - Get(4) -> GET_RESP.
  - Intent(5) -> PUT_ACK; responds HintAck(2), error=0.
  - Put(0,1) or Arith/Logical(2,3):
    - The first beat counts as beat 0.
    - beats==1 -> PUT_ACK; else -> PUT_COLLECT.
- PUT_COLLECT, each A fire:
  - Write a_data under a_mask, only if !op_err and opcode is 0 or 1.
  - Later beats ignore the a_address and a_size fields.
  - On the last beat -> PUT_ACK.
  - An all-zero mask is legal and writes nothing.
- GET_RESP:
  - d_opcode=AccessAckData(1).
  - d_data = mem[index] combinationally, or 0 if op_err.
  - d_error = op_err.
  - On each D fire: beat++. After the last beat -> IDLE.
  - Latency: Get accepted in cycle N; first d_valid in N+1 unless stalled.
- PUT_ACK:
  - Single beat. d_opcode = AccessAck(0) for opcode 0/1, or HintAck(2) for Intent.
  - d_error = op_err.
  - Arith/Logical opcodes are unsupported: they respond with AccessAckData(1), beats per size, data 0, error=1, and nothing is written.
  - D fire -> IDLE.
- D outputs hold stable while d_valid && !d_ready.
- A write and a read of the same word never occur in the same cycle.

Decomposition:
- Package tilelink_pkg holds:
  - A opcode constants: GET=4, PUTFULL=0, PUTPARTIAL=1, ARITH=2, LOGIC=3, INTENT=5.
  - D opcode constants: ACCESSACK=0, ACCESSACKDATA=1, HINTACK=2.
  - FSM state enum.
- One sub-module, tl_mem_array:
  - MEM_WORDS x 32 storage with byte-enable write and combinational read.
  - Asynchronous clear on reset_n.

Test Plan:
- PutFullData at 0x00010000, size 2, data 0xDEADBEEF, mask 0xF -> one AccessAck with error=0. A following Get at the same address -> AccessAckData, d_data=0xDEADBEEF, d_addr_lo=0.
- PutPartialData at 0x00010004, mask 0x3, data 0x1234ABCD over a zero word -> a Get returns 0x0000ABCD.
- Get at 0x00010040, size 6, with d_ready toggling each cycle -> 16 beats, data from words 16..31 in order, outputs stable during stalls, then state IDLE.
- Get at 0x00000000 -> one beat, error=1, data=0. Get at 0x00010002 size 2 (misaligned) -> error=1. In both cases proto_err stays 0.
- Get with size 7 -> single beat with error=1; proto_err=1 and stays set until reset.
- reset_n pulsed low during beat 5 of a 16-beat Get -> d_valid drops immediately. After release: IDLE, a_ready=1, and a Get on any word returns 0.

Source files
------------

// File: rtl/tilelink_pkg.sv
// Shared TileLink-UL opcode encodings, slave FSM states and burst-length helper.
package tilelink_pkg;

  localparam logic [2:0] PUTFULL    = 3'd0;
  localparam logic [2:0] PUTPARTIAL = 3'd1;
  localparam logic [2:0] ARITH      = 3'd2;
  localparam logic [2:0] LOGIC      = 3'd3;
  localparam logic [2:0] GET        = 3'd4;
  localparam logic [2:0] INTENT     = 3'd5;

  localparam logic [2:0] ACCESSACK     = 3'd0;
  localparam logic [2:0] ACCESSACKDATA = 3'd1;
  localparam logic [2:0] HINTACK       = 3'd2;

  typedef enum logic [1:0] {IDLE, PUT_COLLECT, GET_RESP, PUT_ACK} state_e;

  // Index of the final beat; oversize requests collapse to a single beat.
  function automatic logic [3:0] last_beat(input logic [3:0] size, input int max_size);
    if (size <= 4'd2 || int'(size) > max_size) return 4'd0;
    return 4'((16'd1 << (size - 4'd2)) - 16'd1);
  endfunction

endpackage

// File: rtl/tl_mem_array.sv
// Word storage with per-byte write enables, combinational read, async clear.
module tl_mem_array #(
  parameter int WORDS = 256,
  localparam int AW = $clog2(WORDS)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [3:0]    wmask,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  for (genvar b = 0; b < 4; b++) begin : g_lane
    logic [WORDS-1:0][7:0] lane_q;

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)                lane_q <= '0;
      else if (we && wmask[b])     lane_q[waddr] <= wdata[8*b +: 8];
    end

    assign rdata[8*b +: 8] = lane_q[raddr];
  end

endmodule

// File: rtl/tilelink_ul_mem_slave.sv
// TileLink-UL memory slave: Get/Put bursts into word storage, error acks otherwise.
module tilelink_ul_mem_slave
  import tilelink_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0001_0000,
  parameter int          MEM_WORDS = 256,
  parameter int          MAX_SIZE  = 6
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        a_ready,
  input  logic        a_valid,
  input  logic [2:0]  a_opcode,
  input  logic [2:0]  a_param,
  input  logic [3:0]  a_size,
  input  logic        a_source,
  input  logic [31:0] a_address,
  input  logic [3:0]  a_mask,
  input  logic [31:0] a_data,
  input  logic        d_ready,
  output logic        d_valid,
  output logic [2:0]  d_opcode,
  output logic [1:0]  d_param,
  output logic [3:0]  d_size,
  output logic        d_source,
  output logic        d_sink,
  output logic [1:0]  d_addr_lo,
  output logic [31:0] d_data,
  output logic        d_error,
  input  logic        stall_a,
  input  logic        stall_d,
  output logic        proto_err
);

  localparam int AW = $clog2(MEM_WORDS);

  state_e      state, state_nxt;
  logic [2:0]  op_opcode;
  logic [3:0]  op_size;
  logic        op_source;
  logic [31:0] op_address;
  logic        op_err;
  logic [3:0]  beat;

  logic a_fire, d_fire;
  assign a_ready = reset_n && !stall_a && (state == IDLE || state == PUT_COLLECT);
  assign d_valid = !stall_d && (state == GET_RESP || state == PUT_ACK);
  assign a_fire  = a_valid && a_ready;
  assign d_fire  = d_valid && d_ready;

  // First-beat decode; later beats of a burst reuse the latched request.
  logic [31:0] a_off, op_off;
  logic        a_oversize, a_misalign, a_range, a_unsup, a_err;
  logic [3:0]  a_last, op_last;
  assign a_off      = a_address - BASE_ADDR;
  assign op_off     = op_address - BASE_ADDR;
  assign a_oversize = a_size > 4'(MAX_SIZE);
  assign a_misalign = (a_address & ((32'd1 << a_size) - 32'd1)) != 32'd0;
  assign a_range    = a_off >= 32'(4 * MEM_WORDS);
  assign a_unsup    = !(a_opcode inside {GET, PUTFULL, PUTPARTIAL, INTENT});
  assign a_err      = a_oversize || a_misalign || a_range || a_unsup;
  assign a_last     = last_beat(a_size, MAX_SIZE);
  assign op_last    = last_beat(op_size, MAX_SIZE);

  logic [AW-1:0] a_idx, op_idx;
  logic          mem_we;
  logic [31:0]   mem_rdata;
  assign a_idx  = a_off[AW+1:2];
  assign op_idx = op_off[AW+1:2] + AW'(beat);
  assign mem_we = a_fire && ((state == IDLE)
                  ? (!a_err && a_opcode inside {PUTFULL, PUTPARTIAL})
                  : (!op_err && op_opcode inside {PUTFULL, PUTPARTIAL}));

  tl_mem_array #(.WORDS(MEM_WORDS)) u_mem (
    .clock  (clock),
    .reset_n(reset_n),
    .we     (mem_we),
    .waddr  ((state == IDLE) ? a_idx : op_idx),
    .wdata  (a_data),
    .wmask  (a_mask),
    .raddr  (op_idx),
    .rdata  (mem_rdata)
  );

  always_comb begin
    state_nxt = state;
    d_opcode  = ACCESSACK;
    d_data    = 32'd0;
    d_error   = op_err;
    case (state)
      IDLE: if (a_fire) begin
        case (a_opcode)
          GET:                             state_nxt = GET_RESP;
          INTENT:                          state_nxt = PUT_ACK;
          PUTFULL, PUTPARTIAL, ARITH, LOGIC: state_nxt = (a_last == 4'd0) ? PUT_ACK : PUT_COLLECT;
          default:                         state_nxt = PUT_ACK;
        endcase
      end
      PUT_COLLECT: if (a_fire && beat == op_last) state_nxt = PUT_ACK;
      GET_RESP: begin
        d_opcode = ACCESSACKDATA;
        d_data   = op_err ? 32'd0 : mem_rdata;
        if (d_fire && beat == op_last) state_nxt = IDLE;
      end
      PUT_ACK: begin
        // Atomics are refused with a full-length, zero-data error burst.
        if (op_opcode inside {ARITH, LOGIC}) begin
          d_opcode = ACCESSACKDATA;
          if (d_fire && beat == op_last) state_nxt = IDLE;
        end else begin
          d_opcode = (op_opcode == INTENT) ? HINTACK : ACCESSACK;
          if (d_fire) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op_opcode  <= '0;
      op_size    <= '0;
      op_source  <= 1'b0;
      op_address <= '0;
      op_err     <= 1'b0;
      beat       <= '0;
      proto_err  <= 1'b0;
    end else if (state == IDLE) begin
      if (a_fire) begin
        op_opcode  <= a_opcode;
        op_size    <= a_size;
        op_source  <= a_source;
        op_address <= a_address;
        op_err     <= a_err;
        beat       <= (state_nxt == PUT_COLLECT) ? 4'd1 : 4'd0;
        if (a_oversize) proto_err <= 1'b1;
      end
    end else if (state == PUT_COLLECT) begin
      if (a_fire) beat <= (state_nxt == PUT_ACK) ? 4'd0 : beat + 4'd1;
    end else if (d_fire) begin
      beat <= (state_nxt == IDLE) ? 4'd0 : beat + 4'd1;
    end
  end

  assign d_param   = 2'd0;
  assign d_sink    = 1'b0;
  assign d_size    = op_size;
  assign d_source  = op_source;
  assign d_addr_lo = op_address[1:0];

  logic unused_ok;
  assign unused_ok = ^{a_param, op_off};

endmodule

// File: tb/tb_tilelink_ul_mem_slave.sv
// Directed bench for tilelink_ul_mem_slave with hand-computed expectations.
module tb_tilelink_ul_mem_slave;
  import tilelink_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        a_ready, a_valid = 1'b0;
  logic [2:0]  a_opcode = '0, a_param = '0;
  logic [3:0]  a_size = '0, a_mask = '0;
  logic        a_source = 1'b0;
  logic [31:0] a_address = '0, a_data = '0;
  logic        d_ready = 1'b0, d_valid;
  logic [2:0]  d_opcode;
  logic [1:0]  d_param, d_addr_lo;
  logic [3:0]  d_size;
  logic        d_source, d_sink, d_error;
  logic [31:0] d_data;
  logic        stall_a = 1'b0, stall_d = 1'b0, proto_err;

  int passed = 0;
  int total  = 0;
  logic [31:0] burst [16];

  always #5 clock = ~clock;

  tilelink_ul_mem_slave dut (
    .clock(clock), .reset_n(reset_n),
    .a_ready(a_ready), .a_valid(a_valid), .a_opcode(a_opcode), .a_param(a_param),
    .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
    .a_data(a_data), .d_ready(d_ready), .d_valid(d_valid), .d_opcode(d_opcode),
    .d_param(d_param), .d_size(d_size), .d_source(d_source), .d_sink(d_sink),
    .d_addr_lo(d_addr_lo), .d_data(d_data), .d_error(d_error),
    .stall_a(stall_a), .stall_d(stall_d), .proto_err(proto_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Presents one A beat from a negedge, holds it through the accepting edge, returns at a negedge.
  task automatic a_beat(input logic [2:0] op, input logic [3:0] size, input logic src,
                        input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data);
    int n = 0;
    a_valid = 1'b1; a_opcode = op; a_size = size; a_source = src;
    a_address = addr; a_mask = mask; a_data = data;
    while (!a_ready && n < 50) begin @(negedge clock); n++; end
    if (!a_ready) chk("a_ready_timeout", {31'd0, a_ready}, 32'd1);
    @(posedge clock);
    @(negedge clock);
    a_valid = 1'b0;
  endtask

  task automatic d_expect(input string tag, input logic [2:0] op, input logic chk_data,
                          input logic [31:0] data, input logic err);
    int n = 0;
    while (!d_valid && n < 50) begin @(negedge clock); n++; end
    chk({tag, "_valid"}, {31'd0, d_valid}, 32'd1);
    chk({tag, "_opcode"}, {29'd0, d_opcode}, {29'd0, op});
    chk({tag, "_error"}, {31'd0, d_error}, {31'd0, err});
    if (chk_data) chk({tag, "_data"}, d_data, data);
    d_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    d_ready = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) burst[i] = 32'hC0DE_0000 + 32'(i * 17);

    #2;
    chk("rst_a_ready", {31'd0, a_ready}, 32'd0);
    chk("rst_d_valid", {31'd0, d_valid}, 32'd0);
    chk("rst_proto_err", {31'd0, proto_err}, 32'd0);
    @(negedge clock); @(negedge clock);
    reset_n = 1'b1;
    #1;
    chk("post_rst_a_ready", {31'd0, a_ready}, 32'd1);
    @(negedge clock);

    a_beat(PUTFULL, 4'd2, 1'b1, 32'h0001_0000, 4'hF, 32'hDEAD_BEEF);
    chk("put_src", {31'd0, d_source}, 32'd1);
    d_expect("put_ack", ACCESSACK, 1'b0, 32'd0, 1'b0);
    a_beat(GET, 4'd2, 1'b0, 32'h0001_0000, 4'hF, 32'd0);
    chk("get0_addr_lo", {30'd0, d_addr_lo}, 32'd0);
    chk("get0_size", {28'd0, d_size}, 32'd2);
    d_expect("get0", ACCESSACKDATA, 1'b1, 32'hDEAD_BEEF, 1'b0);

    a_beat(PUTPARTIAL, 4'd2, 1'b0, 32'h0001_0004, 4'h3, 32'h1234_ABCD);
    d_expect("pp_ack", ACCESSACK, 1'b0, 32'd0, 1'b0);
    a_beat(GET, 4'd2, 1'b0, 32'h0001_0004, 4'hF, 32'd0);
    d_expect("get_pp", ACCESSACKDATA, 1'b1, 32'h0000_ABCD, 1'b0);

    a_beat(PUTPARTIAL, 4'd2, 1'b0, 32'h0001_0000, 4'h0, 32'h5555_5555);
    d_expect("zmask_ack", ACCESSACK, 1'b0, 32'd0, 1'b0);
    a_beat(GET, 4'd2, 1'b0, 32'h0001_0000, 4'hF, 32'd0);
    d_expect("get_zmask", ACCESSACKDATA, 1'b1, 32'hDEAD_BEEF, 1'b0);

    for (int i = 0; i < 16; i++)
      a_beat(PUTFULL, 4'd6, 1'b0, (i == 0) ? 32'h0001_0040 : 32'hFFFF_FFFF, 4'hF, burst[i]);
    d_expect("burst_put_ack", ACCESSACK, 1'b0, 32'd0, 1'b0);

    a_beat(GET, 4'd6, 1'b0, 32'h0001_0040, 4'hF, 32'd0);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("bget_valid%0d", i), {31'd0, d_valid}, 32'd1);
      chk($sformatf("bget_data%0d", i), d_data, burst[i]);
      d_ready = 1'b0;
      @(posedge clock); @(negedge clock);
      chk($sformatf("bget_hold%0d", i), d_data, burst[i]);
      d_ready = 1'b1;
      @(posedge clock); @(negedge clock);
      d_ready = 1'b0;
    end
    chk("bget_idle", 32'(dut.state), 32'(IDLE));
    chk("bget_dvalid_low", {31'd0, d_valid}, 32'd0);

    a_beat(GET, 4'd2, 1'b0, 32'h0000_0000, 4'hF, 32'd0);
    d_expect("get_oor", ACCESSACKDATA, 1'b1, 32'd0, 1'b1);
    a_beat(GET, 4'd2, 1'b0, 32'h0001_0002, 4'hF, 32'd0);
    d_expect("get_misal", ACCESSACKDATA, 1'b1, 32'd0, 1'b1);
    chk("proto_err_clear", {31'd0, proto_err}, 32'd0);

    a_beat(GET, 4'd7, 1'b0, 32'h0001_0000, 4'hF, 32'd0);
    chk("proto_err_set", {31'd0, proto_err}, 32'd1);
    d_expect("get_big", ACCESSACKDATA, 1'b1, 32'd0, 1'b1);
    chk("bget_idle2", 32'(dut.state), 32'(IDLE));

    a_beat(ARITH, 4'd2, 1'b0, 32'h0001_0000, 4'hF, 32'h0000_0001);
    d_expect("arith", ACCESSACKDATA, 1'b1, 32'd0, 1'b1);
    a_beat(INTENT, 4'd2, 1'b0, 32'h0001_0000, 4'hF, 32'd0);
    d_expect("intent", HINTACK, 1'b0, 32'd0, 1'b0);
    a_beat(GET, 4'd2, 1'b0, 32'h0001_0000, 4'hF, 32'd0);
    d_expect("get_after_arith", ACCESSACKDATA, 1'b1, 32'hDEAD_BEEF, 1'b0);
    chk("proto_err_sticky", {31'd0, proto_err}, 32'd1);

    a_beat(GET, 4'd6, 1'b0, 32'h0001_0040, 4'hF, 32'd0);
    d_ready = 1'b1;
    repeat (5) begin @(posedge clock); @(negedge clock); end
    d_ready = 1'b0;
    chk("rst_beat5_data", d_data, burst[5]);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_dvalid", {31'd0, d_valid}, 32'd0);
    chk("rst_mid_aready", {31'd0, a_ready}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    chk("rst2_idle", 32'(dut.state), 32'(IDLE));
    chk("rst2_aready", {31'd0, a_ready}, 32'd1);
    chk("rst2_proto_err", {31'd0, proto_err}, 32'd0);
    @(negedge clock);
    a_beat(GET, 4'd2, 1'b0, 32'h0001_0000, 4'hF, 32'd0);
    d_expect("rst2_get0", ACCESSACKDATA, 1'b1, 32'd0, 1'b0);
    a_beat(GET, 4'd2, 1'b0, 32'h0001_0044, 4'hF, 32'd0);
    d_expect("rst2_get17", ACCESSACKDATA, 1'b1, 32'd0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
